// File: rtl/dllp_ack_rx.sv
// ACK/NAK DLLP receiver: frames 3-word DLLPs, checks CRC-16 and the sequence window,
// and owns the replay timer and replay counter feeding the replay buffer.
module dllp_ack_rx #(
    parameter int TIMEOUT = 711
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dllp_valid,
    input  logic        dllp_sop,
    input  logic [15:0] dllp_word,
    input  logic        tlp_sent,
    input  logic [11:0] tx_seq,
    output logic [1:0]  ack_nack,
    output logic [11:0] seq,
    output logic        tim_out,
    output logic        retrain,
    output logic        dllp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W1   = 2'd1,
        ST_W2   = 2'd2
    } state_t;

    localparam logic [7:0]  TYPE_ACK = 8'h00;
    localparam logic [7:0]  TYPE_NAK = 8'h10;
    localparam logic [11:0] TMO_LAST = 12'(TIMEOUT - 1);
    localparam logic [15:0] CRC_POLY = 16'h100B;

    function automatic logic [15:0] crc16_upd(input logic [15:0] crc_in, input logic [15:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  type_q, type_d;
    logic [11:0] rxseq_q, rxseq_d;
    logic [15:0] crc_q, crc_d;
    logic [11:0] ackd_q, ackd_d;
    logic [11:0] last_tx_q, last_tx_d;
    logic [11:0] timer_q, timer_d;
    logic [1:0]  replay_q, replay_d;
    logic [1:0]  ack_nack_q, ack_nack_d;
    logic [11:0] seq_q, seq_d;
    logic        tim_out_q, tim_out_d;
    logic        retrain_q, retrain_d;
    logic        dllp_err_q, dllp_err_d;

    logic        w2_done_s;
    logic        crc_ok_s;
    logic        is_ack_s;
    logic        is_nak_s;
    logic [11:0] d_seq_s;
    logic [11:0] d_last_s;
    logic        ack_acc_s;
    logic        nak_acc_s;
    logic        running_s;
    logic        tim_fire_s;

    // Word framing: a SOP word always restarts framing, even mid-DLLP.
    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        rxseq_d   = rxseq_q;
        crc_d     = crc_q;
        w2_done_s = 1'b0;
        if (dllp_valid) begin
            if (dllp_sop) begin
                state_d = ST_W1;
                type_d  = dllp_word[15:8];
                crc_d   = crc16_upd(16'hFFFF, dllp_word);
            end else begin
                case (state_q)
                    ST_W1: begin
                        crc_d   = crc16_upd(crc_q, dllp_word);
                        rxseq_d = dllp_word[11:0];
                        state_d = ST_W2;
                    end
                    ST_W2: begin
                        w2_done_s = 1'b1;
                        state_d   = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Validation, replay timer, replay counter and output next-state.
    always_comb begin
        crc_ok_s   = (crc_q == dllp_word);
        is_ack_s   = (type_q == TYPE_ACK);
        is_nak_s   = (type_q == TYPE_NAK);
        d_seq_s    = rxseq_q - ackd_q;
        d_last_s   = last_tx_q - ackd_q;
        ack_acc_s  = w2_done_s && crc_ok_s && is_ack_s && (d_seq_s != 12'd0) && (d_seq_s <= d_last_s);
        nak_acc_s  = w2_done_s && crc_ok_s && is_nak_s && (d_seq_s <= d_last_s);
        running_s  = (last_tx_q != ackd_q);
        tim_fire_s = running_s && (timer_q == TMO_LAST);

        dllp_err_d = w2_done_s && (!crc_ok_s || ((is_ack_s || is_nak_s) && !ack_acc_s && !nak_acc_s));
        tim_out_d  = tim_fire_s;
        retrain_d  = 1'b0;
        replay_d   = replay_q;
        ack_nack_d = 2'b00;
        seq_d      = seq_q;
        ackd_d     = ackd_q;

        if (ack_acc_s || nak_acc_s) begin
            ack_nack_d = ack_acc_s ? 2'b01 : 2'b10;
            seq_d      = rxseq_q;
            ackd_d     = rxseq_q;
        end else begin
            ack_nack_d = 2'b00;
        end

        // Range check above used last_tx before this cycle's tlp_sent.
        if (tlp_sent) begin
            last_tx_d = tx_seq;
        end else begin
            last_tx_d = last_tx_q;
        end

        if (ack_acc_s) begin
            replay_d = 2'b00;
        end else if (nak_acc_s || tim_fire_s) begin
            replay_d  = replay_q + 2'd1;
            retrain_d = (replay_q == 2'd3);
        end else begin
            replay_d = replay_q;
        end

        if (last_tx_d == ackd_d) begin
            timer_d = 12'd0;
        end else if (ack_acc_s || nak_acc_s || tim_fire_s || !running_s) begin
            timer_d = 12'd0;
        end else begin
            timer_d = timer_q + 12'd1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            type_q     <= 8'h00;
            rxseq_q    <= 12'h000;
            crc_q      <= 16'hFFFF;
            ackd_q     <= 12'hFFF;
            last_tx_q  <= 12'hFFF;
            timer_q    <= 12'd0;
            replay_q   <= 2'b00;
            ack_nack_q <= 2'b00;
            seq_q      <= 12'h000;
            tim_out_q  <= 1'b0;
            retrain_q  <= 1'b0;
            dllp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            rxseq_q    <= rxseq_d;
            crc_q      <= crc_d;
            ackd_q     <= ackd_d;
            last_tx_q  <= last_tx_d;
            timer_q    <= timer_d;
            replay_q   <= replay_d;
            ack_nack_q <= ack_nack_d;
            seq_q      <= seq_d;
            tim_out_q  <= tim_out_d;
            retrain_q  <= retrain_d;
            dllp_err_q <= dllp_err_d;
        end
    end

    assign ack_nack = ack_nack_q;
    assign seq      = seq_q;
    assign tim_out  = tim_out_q;
    assign retrain  = retrain_q;
    assign dllp_err = dllp_err_q;

endmodule

// File: tb/tb_dllp_ack_rx.sv
// Scoreboard bench for dllp_ack_rx: directed DLLP/TLP stimulus pushes timed
// expected output events; a forked monitor matches every DUT output event.
module tb_dllp_ack_rx;

    localparam logic [7:0] ACK = 8'h00;
    localparam logic [7:0] NAK = 8'h10;

    typedef struct {
        int         cyc;
        logic [1:0] an;
        logic [11:0] sq;
        logic       to;
        logic       rt;
        logic       er;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dllp_valid = 1'b0;
    logic        dllp_sop = 1'b0;
    logic [15:0] dllp_word = 16'h0000;
    logic        tlp_sent = 1'b0;
    logic [11:0] tx_seq = 12'h000;
    logic [1:0]  ack_nack;
    logic [11:0] seq;
    logic        tim_out;
    logic        retrain;
    logic        dllp_err;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q[$];

    dllp_ack_rx #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .dllp_valid(dllp_valid), .dllp_sop(dllp_sop),
        .dllp_word(dllp_word), .tlp_sent(tlp_sent), .tx_seq(tx_seq),
        .ack_nack(ack_nack), .seq(seq), .tim_out(tim_out),
        .retrain(retrain), .dllp_err(dllp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] crc_msg(input logic [15:0] w0, input logic [15:0] w1);
        logic [31:0] m;
        logic [15:0] c;
        m = {w0, w1};
        c = 16'hFFFF;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ m[i]) c = {c[14:0], 1'b0} ^ 16'h100B;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    task automatic push_exp(input int c, input logic [1:0] an, input logic [11:0] sq,
                            input logic to, input logic rt, input logic er);
        exp_t e;
        int   pos;
        e = '{cyc: c, an: an, sq: sq, to: to, rt: rt, er: er};
        pos = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc > c) begin
                pos = i;
                break;
            end
        end
        q.insert(pos, e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, want);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missing_event required at cyc=%0d an=%b seq=%0d to=%b rt=%b err=%b",
                             e.cyc, e.an, e.sq, e.to, e.rt, e.er);
                end
                if (ack_nack != 2'b00 || tim_out || retrain || dllp_err) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event cyc=%0d actual an=%b seq=%0d to=%b rt=%b err=%b",
                                 cyc, ack_nack, seq, tim_out, retrain, dllp_err);
                    end else begin
                        e = q.pop_front();
                        if (e.cyc != cyc || e.an !== ack_nack || e.sq !== seq || e.to !== tim_out ||
                            e.rt !== retrain || e.er !== dllp_err) begin
                            failures++;
                            $display("FAIL event actual cyc=%0d an=%b seq=%0d to=%b rt=%b err=%b required cyc=%0d an=%b seq=%0d to=%b rt=%b err=%b",
                                     cyc, ack_nack, seq, tim_out, retrain, dllp_err,
                                     e.cyc, e.an, e.sq, e.to, e.rt, e.er);
                        end
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic tlp(input logic [11:0] s);
        tlp_sent = 1'b1;
        tx_seq   = s;
        step();
        tlp_sent = 1'b0;
    endtask

    task automatic word(input logic sop, input logic [15:0] w);
        dllp_valid = 1'b1;
        dllp_sop   = sop;
        dllp_word  = w;
        step();
        dllp_valid = 1'b0;
        dllp_sop   = 1'b0;
    endtask

    // Sends W0/W1/W2; crc_xor corrupts W2. Expected event lands the cycle after W2.
    task automatic send_dllp(input logic [7:0] typ, input logic [11:0] sq, input logic [15:0] crc_xor,
                             input bit push, input logic [1:0] an, input logic [11:0] exp_sq, input logic er);
        logic [15:0] w0, w1;
        w0 = {typ, 8'h00};
        w1 = {4'h0, sq};
        word(1'b1, w0);
        word(1'b0, w1);
        word(1'b0, crc_msg(w0, w1) ^ crc_xor);
        if (push) push_exp(cyc, an, exp_sq, 1'b0, 1'b0, er);
    endtask

    initial begin
        int c1, b;
        fork
            monitor();
        join_none

        step();
        step();
        chk("reset_ack_nack", 32'(ack_nack), 32'd0);
        chk("reset_seq",      32'(seq),      32'd0);
        chk("reset_tim_out",  32'(tim_out),  32'd0);
        chk("reset_retrain",  32'(retrain),  32'd0);
        chk("reset_dllp_err", 32'(dllp_err), 32'd0);
        rst = 1'b0;

        // Basic ACK, then a CRC-corrupted ACK, then the restarted timer expiring.
        tlp(12'd0); tlp(12'd1); tlp(12'd2);
        send_dllp(ACK, 12'd1, 16'h0000, 1'b1, 2'b01, 12'd1, 1'b0);
        c1 = cyc;
        push_exp(c1 + 16, 2'b00, 12'd1, 1'b1, 1'b0, 1'b0);
        send_dllp(ACK, 12'd2, 16'h0001, 1'b1, 2'b00, 12'd1, 1'b1);
        wait_until(c1 + 17);
        send_dllp(ACK, 12'd2, 16'h0000, 1'b1, 2'b01, 12'd2, 1'b0);
        send_dllp(8'h20, 12'd2, 16'h0000, 1'b0, 2'b00, 12'd2, 1'b0);
        send_dllp(8'h20, 12'd2, 16'h8000, 1'b1, 2'b00, 12'd2, 1'b1);
        send_dllp(ACK, 12'd2, 16'h0000, 1'b1, 2'b00, 12'd2, 1'b1);

        // Repeated timeouts; the fourth wraps replay_num and retrains.
        tlp(12'd3);
        b = cyc;
        for (int k = 1; k <= 4; k++) push_exp(b + 16 * k, 2'b00, 12'd2, 1'b1, (k == 4), 1'b0);
        wait_until(b + 66);
        send_dllp(NAK, 12'd2, 16'h0000, 1'b1, 2'b10, 12'd2, 1'b0);
        send_dllp(ACK, 12'd3, 16'h0000, 1'b1, 2'b01, 12'd3, 1'b0);

        // Sequence wrap around 4095 -> 0.
        tlp(12'd4094);
        send_dllp(ACK, 12'd4094, 16'h0000, 1'b1, 2'b01, 12'd4094, 1'b0);
        tlp(12'd4095); tlp(12'd0); tlp(12'd1);
        send_dllp(ACK, 12'd0, 16'h0000, 1'b1, 2'b01, 12'd0, 1'b0);
        send_dllp(ACK, 12'd5, 16'h0000, 1'b1, 2'b00, 12'd0, 1'b1);
        send_dllp(ACK, 12'd1, 16'h0000, 1'b1, 2'b01, 12'd1, 1'b0);

        // SOP in the W2 slot aborts the first DLLP.
        tlp(12'd2);
        word(1'b1, {NAK, 8'h00});
        word(1'b0, {4'h0, 12'd7});
        word(1'b1, {ACK, 8'h00});
        word(1'b0, {4'h0, 12'd2});
        word(1'b0, crc_msg({ACK, 8'h00}, {4'h0, 12'd2}));
        push_exp(cyc, 2'b01, 12'd2, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-DLLP with the timer running.
        chk("seq_before_rst", 32'(seq), 32'd2);
        tlp(12'd3);
        word(1'b1, {ACK, 8'h00});
        word(1'b0, {4'h0, 12'd3});
        #1 rst = 1'b1;
        #1;
        chk("async_ack_nack", 32'(ack_nack), 32'd0);
        chk("async_seq",      32'(seq),      32'd0);
        chk("async_tim_out",  32'(tim_out),  32'd0);
        chk("async_retrain",  32'(retrain),  32'd0);
        chk("async_dllp_err", 32'(dllp_err), 32'd0);
        step();
        step();
        rst = 1'b0;
        word(1'b0, crc_msg({ACK, 8'h00}, {4'h0, 12'd3}));
        tlp(12'd0); tlp(12'd1);
        send_dllp(ACK, 12'd1, 16'h0000, 1'b1, 2'b01, 12'd1, 1'b0);
        send_dllp(ACK, 12'd1, 16'h0000, 1'b1, 2'b00, 12'd1, 1'b1);

        for (int i = 0; i < 24; i++) step();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event required at cyc=%0d an=%b seq=%0d to=%b rt=%b err=%b",
                     e.cyc, e.an, e.sq, e.to, e.rt, e.er);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
